// File: rtl/spi_cmd_scheduler.sv
// spi_cmd_scheduler: round-robin arbiter for two requesters that posts one command word at a time
// into the SPI command buffer, polls its slot until the SPI master sets ready, then clears the slot.
module spi_cmd_scheduler #(
    parameter int DEPTH       = 256,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic        req0_rd,
    input  logic [6:0]  req0_addr,
    input  logic [7:0]  req0_wdata,
    output logic        req0_done,
    input  logic        req1_valid,
    input  logic        req1_rd,
    input  logic [6:0]  req1_addr,
    input  logic [7:0]  req1_wdata,
    output logic        req1_done,
    output logic [7:0]  rsp_data,
    output logic        rsp_err,
    output logic [7:0]  buf_addra,
    output logic [31:0] buf_dina,
    output logic        buf_wea,
    input  logic [31:0] buf_douta,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC);

    typedef enum logic [2:0] {IDLE, WRITE, PADDR, PDATA, CLEAR, DONE} state_t;

    state_t        state, nxt;
    logic          gnt, last_gnt, rd, err, gnt_nxt, ready, expired, any_valid;
    logic [6:0]    addr;
    logic [7:0]    wdata;
    logic [AW-1:0] wr_ptr;
    logic [TW-1:0] tmo_cnt;
    logic          unused;

    assign any_valid = req0_valid || req1_valid;
    assign gnt_nxt   = (req0_valid && req1_valid) ? !last_gnt : req1_valid;
    assign ready     = buf_douta[31];
    assign expired   = tmo_cnt == TW'(TIMEOUT_CYC - 1);
    assign busy      = state != IDLE;
    assign rsp_err   = err;
    assign unused    = ^{buf_douta[30:15], buf_douta[6:0]};

    always_comb begin
        nxt       = state;
        buf_addra = 8'd0;
        buf_dina  = 32'd0;
        buf_wea   = 1'b0;
        req0_done = 1'b0;
        req1_done = 1'b0;
        case (state)
            IDLE:  nxt = any_valid ? WRITE : IDLE;
            WRITE: begin
                buf_addra = 8'(wr_ptr);
                buf_dina  = {2'b01, rd, 14'd0, rd ? 8'd0 : wdata, addr};
                buf_wea   = 1'b1;
                nxt       = PADDR;
            end
            PADDR: begin
                buf_addra = 8'(wr_ptr);
                nxt       = PDATA;
            end
            PDATA: begin
                buf_addra = 8'(wr_ptr);
                nxt       = (ready || expired) ? CLEAR : PADDR;
            end
            CLEAR: begin
                buf_addra = 8'(wr_ptr);
                buf_wea   = 1'b1;
                nxt       = DONE;
            end
            DONE: begin
                req0_done = !gnt;
                req1_done = gnt;
                nxt       = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            gnt      <= 1'b0;
            last_gnt <= 1'b1;
            rd       <= 1'b0;
            addr     <= 7'd0;
            wdata    <= 8'd0;
            wr_ptr   <= '0;
            tmo_cnt  <= '0;
            err      <= 1'b0;
            rsp_data <= 8'd0;
        end else begin
            state <= nxt;
            if (state == IDLE && any_valid) begin
                gnt      <= gnt_nxt;
                last_gnt <= gnt_nxt;
                rd       <= gnt_nxt ? req1_rd : req0_rd;
                addr     <= gnt_nxt ? req1_addr : req0_addr;
                wdata    <= gnt_nxt ? req1_wdata : req0_wdata;
            end
            if (state == WRITE)
                tmo_cnt <= '0;
            // one poll is a PADDR/PDATA pair; the count advances only on a miss
            if (state == PDATA) begin
                if (ready) begin
                    rsp_data <= rd ? buf_douta[14:7] : 8'd0;
                    err      <= 1'b0;
                end else if (expired) begin
                    rsp_data <= 8'd0;
                    err      <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
            if (state == CLEAR)
                wr_ptr <= wr_ptr + 1'b1;
        end
    end
endmodule

// File: tb/tb_spi_cmd_scheduler.sv
// tb_spi_cmd_scheduler: randomized requesters and a buffer/SPI-master model; a transaction-level
// reference predicts every write, poll, clear and done from the protocol timing rules.
module tb_spi_cmd_scheduler;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic        clk = 1'b0, rst = 1'b0;
    logic [1:0]  v = 2'b00, rdv = 2'b00;
    logic [6:0]  av [2];
    logic [7:0]  wv [2];
    logic        req0_done, req1_done, rsp_err, buf_wea, busy;
    logic [7:0]  rsp_data, buf_addra;
    logic [31:0] buf_dina, buf_douta = 32'd0;

    spi_cmd_scheduler #(.DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(v[0]), .req0_rd(rdv[0]), .req0_addr(av[0]), .req0_wdata(wv[0]), .req0_done(req0_done),
        .req1_valid(v[1]), .req1_rd(rdv[1]), .req1_addr(av[1]), .req1_wdata(wv[1]), .req1_done(req1_done),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .buf_addra(buf_addra), .buf_dina(buf_dina), .buf_wea(buf_wea), .buf_douta(buf_douta),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int passes = 0, total = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // reference state: one outstanding command described by its grant edge and final poll index
    int          cyc = 0, next_arb = 0, slot_m = 0, cur_slot = 0, g = 0, done_edge = 0;
    int          n_m, kf_m, ready_at = -1, rslot = 0;
    bit          last_gnt = 1'b1, active = 1'b0, gnt_m, rd_m, to_m, exp_err;
    logic [31:0] cmd_m, rword;
    logic [7:0]  exp_data;
    logic [31:0] mem [256];
    bit          force_en = 1'b0;
    int          force_n = 0;
    logic [31:0] force_word = 32'd0;
    logic        s_wea = 1'b0;
    logic [7:0]  s_addra = 8'd0;
    logic [31:0] s_dina = 32'd0;
    logic [31:0] last_cmd_word = 32'd0;
    int          last_slot = -1;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        forever begin
            @(posedge clk);
            cyc++;
            if (cyc == ready_at) mem[rslot] = rword;
            if (s_wea) mem[s_addra] = s_dina;
            buf_douta <= mem[s_addra];
            if (!rst) begin
                active = 1'b0; next_arb = cyc + 1; last_gnt = 1'b1; slot_m = 0; ready_at = -1;
            end else if (cyc >= next_arb && v != 2'b00) begin
                gnt_m    = (v == 2'b11) ? !last_gnt : v[1];
                last_gnt = gnt_m;
                rd_m     = rdv[gnt_m];
                cmd_m    = {2'b01, rd_m, 14'd0, rd_m ? 8'd0 : wv[gnt_m], av[gnt_m]};
                n_m      = force_en ? force_n : ($urandom_range(0, 4) == 0 ? 99 : int'($urandom_range(0, 17)));
                to_m     = n_m >= TMO;
                kf_m     = to_m ? TMO - 1 : n_m;
                rword    = force_en ? force_word : {1'b1, 31'($urandom)};
                g        = cyc;
                rslot    = slot_m;
                ready_at = to_m ? -1 : g + 2 + 2 * n_m - ((!force_en && n_m > 0 && $urandom_range(0, 1) == 1) ? 1 : 0);
                exp_data = (to_m || !rd_m) ? 8'd0 : rword[14:7];
                exp_err  = to_m;
                cur_slot = slot_m;
                slot_m   = (slot_m + 1) % DEPTH;
                done_edge = g + 4 + 2 * kf_m;
                next_arb  = done_edge + 2;
                active    = 1'b1;
            end
        end
    end

    initial begin
        bit in_cmd, wr, clr, dn, poll;
        forever begin
            @(negedge clk);
            s_wea = buf_wea; s_addra = buf_addra; s_dina = buf_dina;
            if (rst) begin
                in_cmd = active && cyc >= g && cyc <= done_edge;
                wr     = active && cyc == g;
                clr    = active && cyc == done_edge - 1;
                dn     = active && cyc == done_edge;
                poll   = in_cmd && cyc < done_edge - 1 && ((cyc - g) % 2 == 1);
                chk("busy", busy, in_cmd);
                chk("wea", buf_wea, wr || clr);
                chk("done0", req0_done, dn && !gnt_m);
                chk("done1", req1_done, dn && gnt_m);
                if (wr) begin
                    chk("cmd_word", buf_dina, cmd_m);
                    chk("cmd_slot", buf_addra, cur_slot);
                    last_cmd_word = buf_dina; last_slot = buf_addra;
                end
                if (poll) chk("poll_slot", buf_addra, cur_slot);
                if (clr) begin
                    chk("clr_word", buf_dina, 0);
                    chk("clr_slot", buf_addra, cur_slot);
                end
                if (dn) begin
                    chk("rsp_data", rsp_data, exp_data);
                    chk("rsp_err", rsp_err, exp_err);
                end
            end
        end
    end

    task automatic run_cmd(input int r, input bit rd, input logic [6:0] a, input logic [7:0] w,
                           input int n, input logic [31:0] word,
                           output int lat, output logic [7:0] d, output logic e);
        bit got = 1'b0;
        force_en = 1'b1; force_n = n; force_word = word;
        @(negedge clk);
        v[r] = 1'b1; rdv[r] = rd; av[r] = a; wv[r] = w;
        lat = 1; d = 8'd0; e = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (r == 1 ? req1_done : req0_done) begin
                got = 1'b1; d = rsp_data; e = rsp_err;
            end
        end
        if (!got) chk("done_timeout", 0, 1);
        v[r] = 1'b0;
    endtask

    initial begin
        int lat, k, c0, c1, dones;
        logic [7:0] d;
        logic e, dn;
        logic [3:0] ord;
        av[0] = 7'd0; av[1] = 7'd0; wv[0] = 8'd0; wv[1] = 8'd0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {busy, buf_wea, req0_done, req1_done, rsp_err, rsp_data, buf_addra}, 0);
        chk("reset_dina", buf_dina, 0);
        #2 rst = 1'b1;

        run_cmd(0, 1'b0, 7'h12, 8'hA5, 9, 32'h8000_0000, lat, d, e);
        chk("t1_word", last_cmd_word, 32'h4000_5292);
        chk("t1_slot", last_slot, 0);
        chk("t1_lat", lat, 24);
        chk("t1_resp", {e, d}, 9'h000);
        chk("t1_cleared", mem[0], 0);

        run_cmd(1, 1'b1, 7'h05, 8'hFF, 0, 32'hC000_2F05, lat, d, e);
        chk("t2_word", last_cmd_word, 32'h6000_0005);
        chk("t2_slot", last_slot, 1);
        chk("t2_lat", lat, 6);
        chk("t2_resp", {e, d}, 9'h05E);

        run_cmd(0, 1'b1, 7'h33, 8'h00, 99, 32'h0, lat, d, e);
        chk("t4_slot", last_slot, 2);
        chk("t4_lat", lat, 36);
        chk("t4_resp", {e, d}, 9'h100);
        chk("t4_cleared", mem[2], 0);

        run_cmd(1, 1'b0, 7'h7F, 8'h01, 2, 32'h8000_0000, lat, d, e);
        chk("t5_slot3", last_slot, 3);
        chk("t5_lat", lat, 10);
        run_cmd(0, 1'b1, 7'h00, 8'h00, 1, 32'hFFFF_FFFF, lat, d, e);
        chk("t5_wrap_slot", last_slot, 0);
        chk("t5_resp", {e, d}, 9'h0FF);

        // reset while polling
        force_n = 99;
        @(negedge clk);
        v[0] = 1'b1; rdv[0] = 1'b0; av[0] = 7'h44; wv[0] = 8'h3C;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 chk("t6_async_outputs", {busy, buf_wea, req0_done, req1_done, rsp_err, rsp_data, buf_addra}, 0);
        chk("t6_async_dina", buf_dina, 0);
        v[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        dones = 0;
        repeat (30) begin
            @(negedge clk);
            dones += int'(req0_done) + int'(req1_done);
        end
        chk("t6_no_done", dones, 0);

        // contention: both held until each has completed twice
        force_n = 0;
        @(negedge clk);
        v = 2'b11; rdv = 2'b00; av[0] = 7'h01; av[1] = 7'h02;
        k = 0; c0 = 0; c1 = 0; ord = 4'd0;
        for (int i = 0; i < 200 && k < 4; i++) begin
            @(negedge clk);
            chk("t3_dual_done", req0_done & req1_done, 0);
            if (req0_done || req1_done) begin
                if (k == 0) chk("t3_slot_after_reset", last_slot, 0);
                ord = {ord[2:0], req1_done};
                k++;
            end
            if (req0_done && ++c0 == 2) v[0] = 1'b0;
            if (req1_done && ++c1 == 2) v[1] = 1'b0;
        end
        chk("t3_count", k, 4);
        chk("t3_order", ord, 4'b0101);

        force_en = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int r = 0; r < 2; r++) begin
                dn = r == 1 ? req1_done : req0_done;
                if (!v[r]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        v[r] = 1'b1; rdv[r] = 1'($urandom); av[r] = 7'($urandom); wv[r] = 8'($urandom);
                    end
                end else if (dn) begin
                    if ($urandom_range(0, 1) == 1) v[r] = 1'b0;
                    else begin rdv[r] = 1'($urandom); av[r] = 7'($urandom); wv[r] = 8'($urandom); end
                end else if ($urandom_range(0, 59) == 0) begin
                    v[r] = 1'b0;
                end else if ($urandom_range(0, 5) == 0) begin
                    rdv[r] = 1'($urandom); av[r] = 7'($urandom); wv[r] = 8'($urandom);
                end
            end
        end
        v = 2'b00;
        repeat (60) @(negedge clk);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
